// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter for a single-port synchronous word RAM.
// Optional MEM_ARB_ROUND_ROBIN_EN: round-robin tie-break in IDLE instead of fixed D priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic [3:0]            d_wmask,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_ack,
    output logic                  mem_en,
    output logic [3:0]            mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } port_t;

    state_t      state_q, state_d;
    port_t       grant_q, grant_d;
    port_t       last_q, last_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_write_q, d_write_d;
    port_t       tie_winner;

    // Byte offset and bits above the RAM size are intentionally dropped (aliasing).
    logic addr_unused;
    assign addr_unused = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0],
                           d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_winner = (last_q == GRANT_I) ? GRANT_D : GRANT_I;
`else
    assign tie_winner = GRANT_D;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_I;
            last_q    <= GRANT_I;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            d_write_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            d_write_q <= d_write_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        d_write_d = d_write_q;
        mem_en    = 1'b0;
        mem_wmask = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_d = tie_winner;
                    state_d = ISSUE;
                end else if (d_req) begin
                    grant_d = GRANT_D;
                    state_d = ISSUE;
                end else if (i_req) begin
                    grant_d = GRANT_I;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                mem_en = 1'b1;
                if (grant_q == GRANT_D) begin
                    mem_addr  = d_addr[ADDR_WIDTH+1:2];
                    mem_wmask = d_wmask;
                    mem_wdata = d_wdata;
                    d_write_d = |d_wmask;
                end else begin
                    mem_addr  = i_addr[ADDR_WIDTH+1:2];
                    d_write_d = 1'b0;
                end
                state_d = RESP;
            end

            RESP: begin
                last_d = grant_q;
                // The served port still holds req here, so only the other port is considered.
                if (grant_q == GRANT_I) begin
                    i_ack     = 1'b1;
                    i_rdata   = mem_rdata;
                    i_rdata_d = mem_rdata;
                    if (d_req) begin
                        grant_d = GRANT_D;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    d_ack = 1'b1;
                    if (!d_write_q) begin
                        d_rdata   = mem_rdata;
                        d_rdata_d = mem_rdata;
                    end
                    if (i_req) begin
                        grant_d = GRANT_I;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and randomized accesses against a word-array model.
// Honours MEM_ARB_ROUND_ROBIN_EN when predicting tie-break order.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [31:0]   i_addr;
    logic [31:0]   i_rdata;
    logic          i_ack;
    logic          d_req;
    logic [3:0]    d_wmask;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ack;
    logic          mem_en;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;
    logic [31:0]   ram [0:WORDS-1];

    logic [31:0]   model_mem [0:WORDS-1];
    logic          model_last;
    logic [31:0]   model_ihold;
    logic [31:0]   model_dhold;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_wmask   (d_wmask),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_wmask (mem_wmask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous single-port RAM with a backdoor load path for preloading.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int k = 0; k < 4; k++)
                if (mem_wmask[k]) ram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int unsigned wordIndex(input logic [31:0] a);
        return (a / 4) % WORDS;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++)
            if (mask[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    function automatic logic tieWinner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !model_last;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [3:0] randMask();
        if ($urandom_range(0, 1) == 0) return 4'b0000;
        return 4'($urandom_range(1, 15));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp_v);
        end
    endtask

    task automatic backdoorWrite(input int unsigned idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_addr = AW'(idx);
        bd_data = data;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        model_mem[idx] = data;
    endtask

    // Apply the served port's transaction to the model and check the returned data.
    task automatic scoreAck(input logic port, input logic [31:0] addr, input logic [3:0] wmask,
                            input logic [31:0] wdata);
        int unsigned idx;
        idx = wordIndex(addr);
        if (!port) begin
            checkOutput("i_rdata", i_rdata, model_mem[idx]);
            model_ihold = model_mem[idx];
        end else if (wmask == 4'b0000) begin
            checkOutput("d_rdata_load", d_rdata, model_mem[idx]);
            model_dhold = model_mem[idx];
        end else begin
            checkOutput("d_rdata_on_write", d_rdata, model_dhold);
            model_mem[idx] = mergeBytes(model_mem[idx], wdata, wmask);
        end
        model_last = port;
    endtask

    // One access from an idle arbiter: req in cycle N, mem_en in N+1, ack in N+2.
    task automatic applyStimulus(input logic port, input logic [31:0] addr, input logic [3:0] wmask,
                                 input logic [31:0] wdata);
        int  lat;
        logic got;
        @(posedge clk);
        #1;
        if (port) begin
            d_req = 1'b1; d_addr = addr; d_wmask = wmask; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                checkOutput("mem_en", 32'(mem_en), 32'd1);
                checkOutput("mem_addr", 32'(mem_addr), wordIndex(addr));
                checkOutput("mem_wmask", 32'(mem_wmask), port ? 32'(wmask) : 32'd0);
                checkOutput("mem_wdata", mem_wdata, port ? wdata : 32'd0);
            end
            if (i_ack || d_ack) got = 1'b1;
        end
        checkOutput("ack_latency", lat, 32'd3);
        checkOutput("served_ack", 32'(port ? d_ack : i_ack), 32'd1);
        checkOutput("other_ack", 32'(port ? i_ack : d_ack), 32'd0);
        if (port) checkOutput("i_rdata_hold", i_rdata, model_ihold);
        else      checkOutput("d_rdata_hold", d_rdata, model_dhold);
        scoreAck(port, addr, wmask, wdata);
        @(posedge clk);
        #1;
        if (port) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    // Both ports saturated for k accesses each; acks must alternate every 2 cycles.
    task automatic runBurst(input int k);
        logic exp_port;
        logic port;
        int   cyc, last_ack, i_cnt, d_cnt;
        @(posedge clk);
        #1;
        i_addr  = $urandom;
        d_addr  = $urandom;
        d_wmask = randMask();
        d_wdata = $urandom;
        i_req   = 1'b1;
        d_req   = 1'b1;
        exp_port = tieWinner();
        cyc = 0; last_ack = -1; i_cnt = 0; d_cnt = 0;
        while ((i_cnt < k || d_cnt < k) && cyc < 20 * k) begin
            @(negedge clk);
            cyc++;
            if (i_ack || d_ack) begin
                checkOutput("ack_exclusive", 32'(i_ack && d_ack), 32'd0);
                port = d_ack;
                checkOutput("grant_order", 32'(port), 32'(exp_port));
                if (last_ack >= 0) checkOutput("ack_spacing", cyc - last_ack, 32'd2);
                last_ack = cyc;
                if (port) scoreAck(1'b1, d_addr, d_wmask, d_wdata);
                else      scoreAck(1'b0, i_addr, 4'b0000, 32'd0);
                exp_port = !port;
                @(posedge clk);
                #1;
                if (port) begin
                    d_cnt++;
                    if (d_cnt < k) begin
                        d_addr = $urandom; d_wmask = randMask(); d_wdata = $urandom;
                    end else d_req = 1'b0;
                end else begin
                    i_cnt++;
                    if (i_cnt < k) i_addr = $urandom;
                    else i_req = 1'b0;
                end
            end
        end
        checkOutput("burst_complete", i_cnt + d_cnt, 2 * k);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0; i_addr = '0;
        d_req   = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
        bd_we   = 1'b0; bd_addr = '0; bd_data = '0;
        model_last = 1'b0; model_ihold = '0; model_dhold = '0;
        #2;
        for (int i = 0; i < WORDS; i++) backdoorWrite(i, $urandom);

        @(negedge clk);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_i_ack", 32'(i_ack), 32'd0);
        checkOutput("rst_d_ack", 32'(d_ack), 32'd0);
        checkOutput("rst_i_rdata", i_rdata, 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        backdoorWrite(5, 32'h0000_0013);
        backdoorWrite(2, 32'hAABB_CCDD);
        applyStimulus(1'b0, 32'h14, 4'b0000, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("fetch_hold", i_rdata, 32'h0000_0013);

        applyStimulus(1'b1, 32'h8, 4'b0011, 32'h1122_3344);
        applyStimulus(1'b1, 32'h8, 4'b0000, 32'd0);
        checkOutput("masked_load", d_rdata, 32'hAABB_3344);
        applyStimulus(1'b1, 32'h408, 4'b0000, 32'd0);
        checkOutput("wrap_load", d_rdata, 32'hAABB_3344);

        for (int n = 0; n < 30; n++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom, randMask(), $urandom);

        // Reset while an instruction read sits in ISSUE.
        @(posedge clk);
        #1;
        i_req  = 1'b1;
        i_addr = $urandom;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_issue_seen", 32'(mem_en), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_i_ack", 32'(i_ack), 32'd0);
        checkOutput("abort_i_rdata", i_rdata, 32'd0);
        checkOutput("abort_d_rdata", d_rdata, 32'd0);
        checkOutput("abort_mem_en", 32'(mem_en), 32'd0);
        i_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_no_ack", 32'(i_ack || d_ack), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_last = 1'b0; model_ihold = '0; model_dhold = '0;
        applyStimulus(1'b0, $urandom, 4'b0000, 32'd0);

        runBurst(6);
        applyStimulus(1'b1, $urandom, 4'b0000, 32'd0);
        runBurst(6);

        for (int n = 0; n < 10; n++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom, randMask(), $urandom);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the SOC's single-port synchronous word memory between the CPU instruction-fetch port and the load/store data port. It replaces direct `MEM[PC[31:2]]` indexing so that loads and stores can reach the same 1 KiB array. It sequences each access through a small FSM and returns read data with a one-cycle acknowledge pulse to the requester.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word-address width of the memory (256 words).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  instruction read request; held until `i_ack`.
- `i_addr`  in  32  instruction byte address.
- `i_rdata`  out  32  instruction read data.
- `i_ack`  out  1  one-cycle completion pulse.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_wmask`  in  4  byte write enables; `4'b0000` means read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data; byte lane k is `[8k+7:8k]`.
- `d_rdata`  out  32  load data.
- `d_ack`  out  1  one-cycle completion pulse.
- `mem_en`  out  1  memory access strobe.
- `mem_wmask`  out  4  byte write enables to the RAM.
- `mem_addr`  out  ADDR_WIDTH  word address.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  RAM read data, valid the cycle after `mem_en`.

## Operation
- **FSM states:** IDLE, ISSUE, RESP. Registered `grant` is I or D. Registered `last` is the port most recently served.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise select a port per the arbitration policy, load `grant`, and go to ISSUE.
- **ISSUE**
  - `mem_en=1`.
  - `mem_addr`, `mem_wmask` and `mem_wdata` come from the granted port. `mem_wmask=0` for the I port.
  - Always go to RESP.
- **RESP**
  - The granted port's ack is 1.
  - The granted port's rdata is driven by `mem_rdata` passthrough. The holding register `x_rdata_q` captures `mem_rdata` at the closing edge.
  - `last` is updated to `grant`.
  - If the other port's req is high, grant it and go to ISSUE (back-to-back). Otherwise go to IDLE.
  - The served port's req in RESP is ignored, since it is still high from its own handshake.
- **rdata outside RESP:** each port's rdata shows its holding register.
- **Writes:** the ack is returned with the same timing as a read. `d_rdata_q` is not updated on a write; the previous load value is kept.
- **Address mapping:** `mem_addr = addr[ADDR_WIDTH+1:2]`.
  - `addr[1:0]` and bits above `ADDR_WIDTH+1` are ignored, so accesses alias and wrap.
  - There is no misalignment fault.
- **Handshake rules:**
  - A requester keeps req, addr, wmask and wdata stable from assertion through its ack cycle.
  - It may drop req or present a new request in the cycle after ack.
  - Inputs sampled only in IDLE/RESP (selection) and ISSUE (payload).

## Timing
- **Latency:** req high in cycle N with the FSM in IDLE gives `mem_en` in N+1 and ack plus valid rdata in N+2.
- **Throughput:**
  - One port alone: 1 access per 3 cycles.
  - Both ports saturated: 1 access per 2 cycles, alternating.
- **Reset values:**
  - State IDLE, `grant=I`, `last=I`.
  - `mem_en=0`, `mem_wmask=0`, `i_ack=0`, `d_ack=0`.
  - `i_rdata_q=0`, `d_rdata_q=0`, `mem_addr=0`, `mem_wdata=0`.
  - `mem_*` are driven to 0 outside ISSUE.
- **Reset mid-access:** reset asserted in ISSUE or RESP aborts the access.
  - No ack is issued and the holding registers clear.
  - A write whose ISSUE cycle already passed the RAM edge may have landed; requesters re-issue after reset.
- **Acks:** `i_ack` and `d_ack` are never high in the same cycle. Each ack is high for exactly one cycle per access.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
- **Defined:** on simultaneous requests in IDLE, the port other than `last` wins. After reset `last=I`, so D wins the first tie.
- **Undefined:** fixed priority, D always wins a tie in IDLE.
  - The RESP back-to-back rule still applies, so I cannot starve beyond one access.
  - A D requester that re-asserts immediately in IDLE still wins.

## Test plan
- **Single fetch:** MEM[5]=0x00000013; I reads `i_addr=0x14`.
  - `mem_en`/`mem_addr=5` in N+1; `i_ack=1`, `i_rdata=0x00000013` in N+2.
  - `i_rdata` still holds the value at N+5.
- **Byte-masked store then load:** MEM[2]=0xAABBCCDD; D writes `d_addr=0x8`, `d_wmask=4'b0011`, `d_wdata=0x11223344`, then reads 0x8.
  - Read returns `d_rdata=0xAABB3344`.
  - `d_rdata` is unchanged during the write's ack.
- **Simultaneous requests, held continuously, macro defined:** grants are D, I, D, I with `mem_en` every 2 cycles and acks strictly alternating.
- **Simultaneous requests in IDLE, macro undefined, D re-requesting the cycle after each ack:** D is served first. I is served via the RESP back-to-back rule, never waiting more than one D access.
- **Address wrap:** `d_addr=0x400+0x8` (ADDR_WIDTH=8) reads MEM[2].
- **Reset during ISSUE of an I read:**
  - `i_ack` never pulses, `i_rdata=0`, the FSM is in IDLE.
  - A fresh request completes normally 2 cycles after reset release.
